// File: rtl/mult_pkg.sv
// Shared types for the shift-and-add multiplier: FSM state encoding and counter sizing.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mult_state_t;

    localparam int DEFAULT_WIDTH = 4;
    localparam int CNT_W = $clog2(DEFAULT_WIDTH);

    // Counter width for an arbitrary operand width; never narrower than one bit.
    function automatic int cnt_w(input int width);
        return (width > 2) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/shift_add_mult_rca.sv
// Parameterised ripple-carry adder (rca_n) built from a chain of full adders.
module rca_n #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic [WIDTH-1:0] s,
    output logic             c_out
);

    logic [WIDTH:0] carry;

    assign carry[0] = c_in;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_fa
            assign s[gi]       = a[gi] ^ b[gi] ^ carry[gi];
            assign carry[gi+1] = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
        end
    endgenerate

    assign c_out = carry[WIDTH];

endmodule

// File: rtl/shift_add_mult.sv
// Sequential unsigned WIDTH x WIDTH shift-and-add multiplier with start/busy/done handshake.
// Optional macro MULT_EARLY_EXIT_EN: finish RUN as soon as no multiplier bits remain set.
module shift_add_mult
    import mult_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = cnt_w(WIDTH);

    mult_state_t        state;
    mult_state_t        state_next;
    logic [CW-1:0]      count;
    logic [WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0] p;
    logic [2*WIDTH-1:0] p_next;
    logic [2*WIDTH-1:0] p_final;
    logic [WIDTH-1:0]   addend;
    logic [WIDTH-1:0]   sum;
    logic               carry;
    logic               last;

    assign addend = p[0] ? mcand : '0;

    rca_n #(.WIDTH(WIDTH)) u_add (
        .a     (p[2*WIDTH-1:WIDTH]),
        .b     (addend),
        .c_in  (1'b0),
        .s     (sum),
        .c_out (carry)
    );

    // Carry lands in the top bit as the whole register shifts right by one.
    assign p_next = {carry, sum, p[WIDTH-1:1]};

`ifdef MULT_EARLY_EXIT_EN
    logic [CW-1:0]    rem;
    logic [WIDTH-1:0] low_mask;

    // rem = multiplier bits still unconsumed after this cycle's update.
    assign rem      = CW'(WIDTH - 1) - count;
    assign low_mask = ~({WIDTH{1'b1}} << rem);
    assign last     = (p_next[WIDTH-1:0] & low_mask) == '0;
    assign p_final  = p_next >> rem;
`else
    assign last    = (count == CW'(WIDTH - 1));
    assign p_final = p_next;
`endif

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = start ? RUN : IDLE;
            RUN:     state_next = last ? DONE : RUN;
            DONE:    state_next = start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mcand   <= '0;
            p       <= '0;
            count   <= '0;
            product <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        mcand <= multiplicand;
                        p     <= {{WIDTH{1'b0}}, multiplier};
                        count <= '0;
                    end
                end
                RUN: begin
                    p     <= last ? p_final : p_next;
                    count <= count + 1'b1;
                    if (last) begin
                        product <= p_final;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule
